// File: rtl/control_unit_fsm_if.sv
// rtl/control_unit_fsm_if.sv - decoder/datapath bundle for control_unit_fsm
// INSTR_COUNT_EN adds the instr_count field.
interface control_unit_fsm_if;
  logic        start;
  logic [3:0]  opcode;
  logic        addressing_mode;
  logic        zero_flag;
  logic        mem_ready;
  logic        ir_load;
  logic        imem_re;
  logic        pc_inc;
  logic        pc_load;
  logic        alu_en;
  logic [3:0]  alu_op;
  logic        reg_we;
  logic        dmem_re;
  logic        dmem_we;
  logic        halted;
  logic        mem_timeout;
  logic [2:0]  state_out;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  modport master (
    input  start, opcode, addressing_mode, zero_flag, mem_ready,
    output ir_load, imem_re, pc_inc, pc_load, alu_en, alu_op, reg_we,
           dmem_re, dmem_we, halted, mem_timeout, state_out
`ifdef INSTR_COUNT_EN
    , output instr_count
`endif
  );

  modport slave (
    output start, opcode, addressing_mode, zero_flag, mem_ready,
    input  ir_load, imem_re, pc_inc, pc_load, alu_en, alu_op, reg_we,
           dmem_re, dmem_we, halted, mem_timeout, state_out
`ifdef INSTR_COUNT_EN
    , input instr_count
`endif
  );
endinterface

// File: rtl/control_unit_fsm.sv
// rtl/control_unit_fsm.sv - multi-cycle fetch/decode/execute sequencer for the 8-bit core
// Optional retired-instruction counter enabled by INSTR_COUNT_EN.
module control_unit_fsm #(
  parameter int MEM_WAIT_MAX     = 15,
  parameter bit RESET_STATE_IDLE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  control_unit_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM_RD = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM_WR = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam state_t     RST_STATE  = RESET_STATE_IDLE ? S_IDLE : S_FETCH;
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX - 1);

  localparam logic [3:0] OP_ALU_LAST = 4'hA;
  localparam logic [3:0] OP_LOAD     = 4'hB;
  localparam logic [3:0] OP_STORE    = 4'hC;
  localparam logic [3:0] OP_JUMP     = 4'hD;
  localparam logic [3:0] OP_BRANCH   = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  // MOVE (0) and the ALU ops (1-A) share the "ALU or move" class.
  function automatic logic is_alu_or_move(input logic [3:0] op);
    return op <= OP_ALU_LAST;
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return (op == 4'h5) || (op == 4'h6) || (op == 4'h9);
  endfunction

  state_t     state, state_next;
  logic [3:0] op_q;
  logic       mode_q;
  logic [7:0] wait_cnt;
  logic       timeout_q;
  logic       mem_state;
  logic       timeout_hit;
  logic       ir_load, imem_re, pc_inc, pc_load, alu_en, reg_we;
  logic       dmem_re, dmem_we, halted;

  assign mem_state   = (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout_hit = mem_state && !bus.mem_ready && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_STATE;
      op_q      <= 4'd0;
      mode_q    <= 1'b0;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_q   <= bus.opcode;
        mode_q <= bus.addressing_mode;
      end
      if (state_next != state)
        wait_cnt <= 8'd0;
      else if (mem_state && !bus.mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    ir_load    = 1'b0;
    imem_re    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start)
          state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_re    = 1'b1;
        ir_load    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_HALT:             state_next = S_HALT;
          OP_JUMP, OP_BRANCH:  state_next = S_EXEC;
          OP_LOAD:             state_next = S_MEM_RD;
          default: begin
            if (is_alu_or_move(bus.opcode) && bus.addressing_mode)
              state_next = S_MEM_RD;
            else
              state_next = S_EXEC;
          end
        endcase
      end
      S_MEM_RD: begin
        dmem_re = 1'b1;
        if (bus.mem_ready)
          state_next = (op_q == OP_LOAD) ? S_WB : S_EXEC;
        else if (timeout_hit)
          state_next = S_HALT;
      end
      S_EXEC: begin
        alu_en = is_alu_or_move(op_q);
        if (op_q == OP_JUMP) begin
          pc_load    = 1'b1;
          state_next = S_FETCH;
        end else if (op_q == OP_BRANCH) begin
          pc_load    = bus.zero_flag;
          pc_inc     = !bus.zero_flag;
          state_next = S_FETCH;
        end else if ((op_q == OP_STORE) || (is_unary(op_q) && mode_q)) begin
          state_next = S_MEM_WR;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM_WR: begin
        dmem_we = 1'b1;
        if (bus.mem_ready)
          state_next = S_WB;
        else if (timeout_hit)
          state_next = S_HALT;
      end
      S_WB: begin
        pc_inc     = 1'b1;
        reg_we     = !((op_q == OP_STORE) || (is_unary(op_q) && mode_q));
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = RST_STATE;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] instr_cnt_q;

  // An instruction retires on leaving WB, or in EXEC for jump/branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instr_cnt_q <= 16'd0;
    else if ((state == S_WB) ||
             ((state == S_EXEC) && ((op_q == OP_JUMP) || (op_q == OP_BRANCH))))
      instr_cnt_q <= instr_cnt_q + 16'd1;
  end

  assign bus.instr_count = instr_cnt_q;
`endif

  assign bus.ir_load     = ir_load;
  assign bus.imem_re     = imem_re;
  assign bus.pc_inc      = pc_inc;
  assign bus.pc_load     = pc_load;
  assign bus.alu_en      = alu_en;
  assign bus.alu_op      = op_q;
  assign bus.reg_we      = reg_we;
  assign bus.dmem_re     = dmem_re;
  assign bus.dmem_we     = dmem_we;
  assign bus.halted      = halted;
  assign bus.mem_timeout = timeout_q;
  assign bus.state_out   = state;

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb/tb_control_unit_fsm.sv - randomized schedule-model bench for control_unit_fsm
// Optional instr_count checks under INSTR_COUNT_EN.
module tb_control_unit_fsm;

  localparam int WAIT_MAX = 15;

  // strobe vector order: ir_load imem_re pc_inc pc_load alu_en reg_we dmem_re dmem_we halted
  localparam logic [8:0] S_FETCH = 9'b110000000;
  localparam logic [8:0] S_INC   = 9'b001000000;
  localparam logic [8:0] S_LD    = 9'b000100000;
  localparam logic [8:0] S_ALU   = 9'b000010000;
  localparam logic [8:0] S_WE    = 9'b000001000;
  localparam logic [8:0] S_RE    = 9'b000000100;
  localparam logic [8:0] S_WR    = 9'b000000010;
  localparam logic [8:0] S_H     = 9'b000000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_unit_fsm_if bus();

  control_unit_fsm #(
    .MEM_WAIT_MAX(WAIT_MAX),
    .RESET_STATE_IDLE(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] sb;
    logic       rdy;
    logic       to;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [15:0] ic_exp;
  logic [8:0]  sb_now;

  assign sb_now = {bus.ir_load, bus.imem_re, bus.pc_inc, bus.pc_load, bus.alu_en,
                   bus.reg_we, bus.dmem_re, bus.dmem_we, bus.halted};

  task automatic push(input int st, input logic [8:0] sb, input logic rdy, input logic to);
    cyc_t c;
    c.st  = 3'(st);
    c.sb  = sb;
    c.rdy = rdy;
    c.to  = to;
    exp_q.push_back(c);
  endtask

  // Expected cycle-by-cycle schedule of one instruction; rw/ww = not-ready cycles
  // before the data memory answers, ww < 0 = memory never answers on a write.
  task automatic build_sched(input logic [3:0] op, input logic mode, input logic zf,
                             input int rw, input int ww);
    logic alu_cls, unary, memrd, memwr;
    logic [8:0] ex;
    exp_q.delete();
    alu_cls = (op <= 4'hA);
    unary   = (op == 4'h5) || (op == 4'h6) || (op == 4'h9);
    memrd   = (op == 4'hB) || (alu_cls && mode);
    memwr   = (op == 4'hC) || (unary && mode);
    push(1, S_FETCH, 1'($urandom), 1'b0);
    push(2, 9'd0, 1'($urandom), 1'b0);
    if (op == 4'hF) begin
      push(7, S_H, 1'($urandom), 1'b0);
      return;
    end
    if (memrd)
      for (int k = 0; k <= rw; k++) push(3, S_RE, k == rw, 1'b0);
    if (op == 4'hB) begin
      push(6, S_INC | S_WE, 1'($urandom), 1'b0);
      return;
    end
    ex = alu_cls ? S_ALU : 9'd0;
    if (op == 4'hD) ex = ex | S_LD;
    if (op == 4'hE) ex = ex | (zf ? S_LD : S_INC);
    push(4, ex, 1'($urandom), 1'b0);
    if (op == 4'hD || op == 4'hE) return;
    if (memwr) begin
      if (ww < 0) begin
        for (int k = 0; k < WAIT_MAX; k++) push(5, S_WR, 1'b0, 1'b0);
        push(7, S_H, 1'($urandom), 1'b1);
        return;
      end
      for (int k = 0; k <= ww; k++) push(5, S_WR, k == ww, 1'b0);
    end
    push(6, memwr ? S_INC : (S_INC | S_WE), 1'($urandom), 1'b0);
  endtask

  task automatic run_sched(input string name, input logic [3:0] op, input logic mode,
                           input logic zf);
    cyc_t c;
    bus.opcode          = op;
    bus.addressing_mode = mode;
    bus.zero_flag       = zf;
    c = exp_q[0];
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      c = exp_q[i];
      bus.mem_ready = c.rdy;
      bus.start     = 1'($urandom);
      total++;
      if (bus.state_out !== c.st)
        $display("FAIL %s cyc%0d state got=%0d want=%0d", name, i, bus.state_out, c.st);
      if (bus.state_out !== c.st) bad++;
      total++;
      if (sb_now !== c.sb) begin
        bad++;
        $display("FAIL %s cyc%0d strobes got=%b want=%b", name, i, sb_now, c.sb);
      end
      total++;
      if (bus.mem_timeout !== c.to) begin
        bad++;
        $display("FAIL %s cyc%0d mem_timeout got=%b want=%b", name, i, bus.mem_timeout, c.to);
      end
      if (c.st >= 3 && c.st <= 6) begin
        total++;
        if (bus.alu_op !== op) begin
          bad++;
          $display("FAIL %s cyc%0d alu_op got=%h want=%h", name, i, bus.alu_op, op);
        end
      end
`ifdef INSTR_COUNT_EN
      total++;
      if (bus.instr_count !== ic_exp) begin
        bad++;
        $display("FAIL %s cyc%0d instr_count got=%0d want=%0d", name, i, bus.instr_count, ic_exp);
      end
`endif
    end
    if (c.st == 3'd6 || (c.st == 3'd4 && (op == 4'hD || op == 4'hE)))
      ic_exp = ic_exp + 16'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    ic_exp = 16'd0;
  endtask

  task automatic test_reset();
    bus.opcode = 4'd0; bus.addressing_mode = 1'b0; bus.zero_flag = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.state_out !== 3'd0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d state got=%0d want=0", i, bus.state_out);
      end
      total++;
      if (sb_now !== 9'd0 || bus.alu_op !== 4'd0 || bus.mem_timeout !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d strobes got=%b alu_op=%h to=%b want=0", i,
                 sb_now, bus.alu_op, bus.mem_timeout);
      end
      bus.mem_ready = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_add();
    bus.start = 1'b1;
    build_sched(4'h1, 1'b0, 1'b0, 0, 0);
    run_sched("add", 4'h1, 1'b0, 1'b0);
  endtask

  task automatic test_load_wait();
    build_sched(4'hB, 1'b0, 1'b0, 3, 0);
    total++;
    if (exp_q.size() != 7) begin
      bad++;
      $display("FAIL load_latency model got=%0d want=7", exp_q.size());
    end
    run_sched("load_wait", 4'hB, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    build_sched(4'hE, 1'b0, 1'b1, 0, 0);
    run_sched("branch_taken", 4'hE, 1'b0, 1'b1);
    build_sched(4'hE, 1'b1, 1'b0, 0, 0);
    run_sched("branch_not", 4'hE, 1'b1, 1'b0);
    build_sched(4'hD, 1'b0, 1'b0, 0, 0);
    run_sched("jump", 4'hD, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic mode, zf;
    for (int n = 0; n < 60; n++) begin
      op   = 4'($urandom_range(0, 14));
      mode = 1'($urandom);
      zf   = 1'($urandom);
      build_sched(op, mode, zf, $urandom_range(0, 3), $urandom_range(0, 3));
      run_sched("random", op, mode, zf);
    end
  endtask

  task automatic test_store_timeout();
    do_reset();
    bus.start = 1'b1;
    build_sched(4'hC, 1'b0, 1'b0, 0, -1);
    run_sched("store_timeout", 4'hC, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.mem_ready = 1'b1;
      total++;
      if (bus.state_out !== 3'd7 || sb_now !== S_H || bus.mem_timeout !== 1'b1) begin
        bad++;
        $display("FAIL timeout_sticky cyc%0d state=%0d strobes=%b to=%b want 7/%b/1", i,
                 bus.state_out, sb_now, bus.mem_timeout, S_H);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus.start = 1'b1;
    build_sched(4'hF, 1'b0, 1'b0, 0, 0);
    run_sched("halt", 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = ~bus.start;
      total++;
      if (bus.state_out !== 3'd7 || sb_now !== S_H) begin
        bad++;
        $display("FAIL halt_hold cyc%0d state=%0d strobes=%b want 7/%b", i,
                 bus.state_out, sb_now, S_H);
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.state_out !== 3'd0 || bus.halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_reset state=%0d halted=%b want 0/0", bus.state_out, bus.halted);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.start = 1'b1;
    build_sched(4'h1, 1'b0, 1'b0, 0, 0);
    run_sched("pre_add", 4'h1, 1'b0, 1'b0);
    build_sched(4'hB, 1'b0, 1'b0, 10, 0);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    run_sched("mid_load", 4'hB, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++;
    if (sb_now !== 9'd0 || bus.state_out !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset strobes=%b state=%0d want 0/0", sb_now, bus.state_out);
    end
`ifdef INSTR_COUNT_EN
    total++;
    if (bus.instr_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset_count got=%0d want=0", bus.instr_count);
    end
`endif
    @(negedge clk);
    rst       = 1'b0;
    ic_exp    = 16'd0;
    bus.start = 1'b1;
    build_sched(4'h1, 1'b0, 1'b0, 0, 0);
    run_sched("post_add", 4'h1, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (bus.state_out !== 3'd1) begin
      bad++;
      $display("FAIL post_add_fetch state got=%0d want=1", bus.state_out);
    end
`ifdef INSTR_COUNT_EN
    total++;
    if (bus.instr_count !== 16'd1) begin
      bad++;
      $display("FAIL post_add_count got=%0d want=1", bus.instr_count);
    end
`endif
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mem_ready = 1'b0;
    ic_exp = 16'd0;
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_random();
    test_store_timeout();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
